// File: rtl/sequencer_if.sv
// Sequencer state type plus the bundle between the sequencer and the core.
// Optional single-step input is present when SEQ_SINGLE_STEP_EN is defined.
package sequencer_pkg;
   localparam int OPCODE_WIDTH = 8;

   typedef enum logic [2:0] {
      SRST   = 3'd0,
      SREAD  = 3'd1,
      SLOAD1 = 3'd2,
      SLOAD2 = 3'd3,
      SLOAD3 = 3'd4,
      SCALC  = 3'd5,
      SWRITE = 3'd6,
      SNXT   = 3'd7
   } sequencer_state_t;
endpackage

interface sequencer_if #(
   parameter int CNT_WIDTH = 16
);
   import sequencer_pkg::*;

   logic                    run;
   logic                    ram_busy;
   logic [OPCODE_WIDTH-1:0] opcode;
`ifdef SEQ_SINGLE_STEP_EN
   logic                    step;
`endif
   sequencer_state_t        q;
   logic                    halted;
   logic                    active;
   logic [CNT_WIDTH-1:0]    cycle_cnt;
   logic [CNT_WIDTH-1:0]    instr_cnt;

   modport master (
`ifdef SEQ_SINGLE_STEP_EN
      input  step,
`endif
      input  run, ram_busy, opcode,
      output q, halted, active, cycle_cnt, instr_cnt
   );

   modport slave (
`ifdef SEQ_SINGLE_STEP_EN
      output step,
`endif
      output run, ram_busy, opcode,
      input  q, halted, active, cycle_cnt, instr_cnt
   );
endinterface

// File: rtl/sequencer.sv
// Program-line control FSM: read, load x3, calc, write, next; stalls on ram_busy, halts on HALT_OPCODE.
// Define SEQ_SINGLE_STEP_EN to gate SNXT on a rising edge of the step input.
module sequencer
   import sequencer_pkg::*;
#(
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 8'hFF,
   parameter int                      CNT_WIDTH   = 16
) (
   input logic         clk,
   input logic         rstn,
   sequencer_if.master bus
);

   sequencer_state_t     state, state_nxt;
   logic                 run_q;
   logic                 run_rise;
   logic                 start;
   logic                 halt_hit;
   logic                 instr_tick;
   logic                 halted;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic [CNT_WIDTH-1:0] instr_cnt;
`ifdef SEQ_SINGLE_STEP_EN
   logic                 step_q;
   logic                 step_rise;

   assign step_rise = bus.step & ~step_q;
`endif

   assign run_rise = bus.run & ~run_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt  = state;
      start      = 1'b0;
      halt_hit   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      instr_tick = (state == SWRITE);
`else
      instr_tick = (state == SNXT);
`endif
      case (state)
         SRST: if (run_rise) begin
            state_nxt = SREAD;
            start     = 1'b1;
         end
         SREAD:  state_nxt = SLOAD1;
         SLOAD1: if (!bus.ram_busy) state_nxt = SLOAD2;
         SLOAD2: if (!bus.ram_busy) state_nxt = SLOAD3;
         SLOAD3: if (!bus.ram_busy) state_nxt = SCALC;
         // A stall outranks the halt check; a halt line skips SWRITE entirely.
         SCALC: if (!bus.ram_busy) begin
            if (bus.opcode == HALT_OPCODE) begin
               state_nxt = SRST;
               halt_hit  = 1'b1;
            end else begin
               state_nxt = SWRITE;
            end
         end
         SWRITE: state_nxt = SNXT;
`ifdef SEQ_SINGLE_STEP_EN
         SNXT: if (step_rise) state_nxt = bus.run ? SREAD : SRST;
`else
         SNXT: state_nxt = bus.run ? SREAD : SRST;
`endif
         default: state_nxt = SRST;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SRST;
         run_q     <= 1'b0;
         halted    <= 1'b0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
`ifdef SEQ_SINGLE_STEP_EN
         step_q    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         run_q <= bus.run;
`ifdef SEQ_SINGLE_STEP_EN
         step_q <= bus.step;
`endif
         if (start) begin
            halted    <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
         end else begin
            if (halt_hit) halted <= 1'b1;
            if (state != SRST && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (instr_tick) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.q         = state;
   assign bus.active    = (state != SRST);
   assign bus.halted    = halted;
   assign bus.cycle_cnt = cycle_cnt;
   assign bus.instr_cnt = instr_cnt;

endmodule
